// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the fifo_drain burst read engine.
package fifo_drain_pkg;

    // Words the skid buffer can hold; also the read credit limit.
    localparam int unsigned SKID_DEPTH = 2;
    // Cycles from FIFO rd_en to its registered dout.
    localparam int unsigned RD_LAT     = 1;
    // Occupancy counter width for the skid buffer (0..SKID_DEPTH).
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);
    // Width wide enough for buffered plus in-flight words.
    localparam int unsigned OCC_W      = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/drain_skid.sv
// Two-entry register buffer; head is always entry 0 and stays put until popped.
module drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [DATA_W-1:0] r_ent0;
    logic [DATA_W-1:0] r_ent1;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pop;
    logic              w_full;

    assign w_pop  = i_pop && (r_cnt != '0);
    assign w_full = (r_cnt == CNT_W'(SKID_DEPTH));
    assign o_head = r_ent0;
    assign o_cnt  = r_cnt;

    // Entry shifting and occupancy; simultaneous push and pop are both honored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_cnt  <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (!w_full) begin
                        if (r_cnt == '0) begin
                            r_ent0 <= i_push_data;
                        end else begin
                            r_ent1 <= i_push_data;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                2'b11: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Burst read engine: pulls len words from a registered-read FIFO onto a valid/ready stream.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  w_issued_nxt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  w_remaining_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_head;
    logic [OCC_W-1:0]  w_occ;
    logic              w_pop;
    logic              w_push;
    logic              w_credit_ok;
    logic              w_rd_en;

    drain_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (din),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_cnt       (w_cnt)
    );

    assign m_valid = (w_cnt != '0);
    assign m_data  = w_head;
    assign w_pop   = m_valid && m_ready;
    assign w_push  = r_rd_pipe[RD_LAT-1];

    // Buffered plus outstanding words must stay below the buffer depth after this cycle's pop.
    assign w_occ       = OCC_W'(w_cnt) + OCC_W'($countones(r_rd_pipe));
    assign w_credit_ok = w_occ < (OCC_W'(SKID_DEPTH) + OCC_W'(w_pop));

    assign rd_en = w_rd_en && !rst;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

    // Next-state, read issue and done-pulse decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_issued_nxt    = r_issued;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_rd_en         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_state_nxt     = RUN;
                        w_remaining_nxt = len;
                        w_issued_nxt    = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                w_rd_en = !empty && (r_issued < r_remaining) && w_credit_ok;
                if (w_rd_en) begin
                    w_issued_nxt = r_issued + LEN_W'(1);
                end
                if (w_issued_nxt >= r_remaining) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((r_rd_pipe == '0) &&
                    ((w_cnt == '0) || ((w_cnt == CNT_W'(1)) && w_pop))) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, burst counters and the read-latency pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issued    <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_rd_pipe   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_issued    <= w_issued_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
            r_rd_pipe   <= RD_LAT'({r_rd_pipe, rd_en});
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain with a behavioral registered-read FIFO and a stream scoreboard.
module tb_fifo_drain;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 8;

    typedef logic [DATA_W-1:0] word_q_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic              empty;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic              wr_en;
    logic              fifo_clr;
    logic [DATA_W-1:0] wr_data;
    int                fifo_cnt = 0;
    logic [DATA_W-1:0] fifo_q[$];

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    int                obs_rd = 0;

    int                rd_cnt = 0;
    int                done_cnt = 0;
    int                busy_cnt = 0;
    int                stall_viol = 0;
    int                credit_viol = 0;
    int                empty_viol = 0;
    int                outstanding = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    fifo_drain #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .empty   (empty),
        .din     (din),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    assign empty = (fifo_cnt == 0);

    // Registered-read FIFO: dout appears the cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
        end else begin
            if (rd_en && fifo_q.size() != 0) din <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(wr_data);
        end
        fifo_cnt <= fifo_q.size();
    end

    // Stream observer: records accepted words and protocol events.
    always @(negedge clk) begin : monitor
        logic pop;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            pop = m_valid && m_ready;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
            if (rd_en && empty) empty_viol++;
            if (rd_en && (outstanding - int'(pop)) >= 2) credit_viol++;
            if (pop) obs_q.push_back(m_data);
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            outstanding = outstanding + int'(rd_en) - int'(pop);
            prev_stall  = m_valid && !m_ready;
            prev_data   = m_data;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_load(input word_q_t w);
        foreach (w[i]) begin
            wr_en   = 1'b1;
            wr_data = w[i];
            next_cycle();
        end
        wr_en = 1'b0;
        next_cycle();
    endtask

    task automatic fifo_clear();
        fifo_clr = 1'b1;
        next_cycle();
        fifo_clr = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", m_data); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        word_q_t words;
        logic [DATA_W-1:0] e;
        int cyc, first_v, last_pop, done_at, rd0, dn0;
        words = '{8'd3, 8'd4, 8'd5, 8'd6};
        fifo_load(words);
        foreach (words[i]) exp_q.push_back(words[i]);
        obs_rd = obs_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        m_ready = 1'b1; start = 1'b1; len = 8'd4;
        first_v = -1; last_pop = -1; done_at = -1; cyc = 0;
        while (cyc < 40 && done_at < 0) begin
            @(negedge clk);
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) last_pop = cyc;
            if (done) done_at = cyc;
            next_cycle(); start = 1'b0; cyc++;
        end
        repeat (2) @(negedge clk);
        total++; if (first_v != 3) begin bad++; $display("FAIL basic_first_valid got=%0d want=3", first_v); end
        total++; if (last_pop != 6) begin bad++; $display("FAIL basic_last_pop got=%0d want=6", last_pop); end
        total++; if (done_at != 7) begin bad++; $display("FAIL basic_done_cycle got=%0d want=7", done_at); end
        total++; if (rd_cnt - rd0 != 4) begin bad++; $display("FAIL basic_rd_count got=%0d want=4", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - dn0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL basic_word got=none want=%0d", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL basic_word got=%0d want=%0d", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL basic_extra got=%0d want=0", obs_q.size() - obs_rd); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        word_q_t words;
        logic [DATA_W-1:0] e;
        int cyc, done_at, rd0, dn0, sv0, cv0;
        words = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
        fifo_load(words);
        foreach (words[i]) exp_q.push_back(words[i]);
        obs_rd = obs_q.size(); rd0 = rd_cnt; dn0 = done_cnt; sv0 = stall_viol; cv0 = credit_viol;
        m_ready = 1'b1; start = 1'b1; len = 8'd5;
        done_at = -1; cyc = 0;
        while (cyc < 80 && done_at < 0) begin
            @(negedge clk);
            if (done) done_at = cyc;
            next_cycle(); start = 1'b0; cyc++;
            m_ready = (cyc % 3 == 0);
        end
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done_at < 0) begin bad++; $display("FAIL bp_done got=timeout want=pulse"); end
        total++; if (rd_cnt - rd0 != 5) begin bad++; $display("FAIL bp_rd_count got=%0d want=5", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", done_cnt - dn0); end
        total++; if (stall_viol != sv0) begin bad++; $display("FAIL bp_stable got=%0d want=0 changes", stall_viol - sv0); end
        total++; if (credit_viol != cv0) begin bad++; $display("FAIL bp_credit got=%0d want=0 overissues", credit_viol - cv0); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL bp_word got=none want=%0d", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL bp_word got=%0d want=%0d", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL bp_extra got=%0d want=0", obs_q.size() - obs_rd); end
        next_cycle();
    endtask

    task automatic test_empty_stall();
        word_q_t words;
        logic [DATA_W-1:0] e;
        int cyc, done_at, rd0, ev0, stall_rd;
        logic busy9;
        words = '{8'd7, 8'd8};
        fifo_load(words);
        exp_q.push_back(8'd7); exp_q.push_back(8'd8); exp_q.push_back(8'd9); exp_q.push_back(8'd10);
        obs_rd = obs_q.size(); rd0 = rd_cnt; ev0 = empty_viol;
        m_ready = 1'b1; start = 1'b1; len = 8'd4;
        done_at = -1; cyc = 0; stall_rd = 0; busy9 = 1'b0;
        while (cyc < 60 && done_at < 0) begin
            @(negedge clk);
            if (cyc >= 3 && cyc <= 10 && rd_en) stall_rd++;
            if (cyc == 9) busy9 = busy;
            if (done) done_at = cyc;
            next_cycle(); start = 1'b0; cyc++;
            wr_en = (cyc == 10 || cyc == 11);
            wr_data = (cyc == 10) ? 8'd9 : 8'd10;
        end
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (stall_rd != 0) begin bad++; $display("FAIL stall_rd_en got=%0d want=0 cycles", stall_rd); end
        total++; if (busy9 !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy9); end
        total++; if (done_at != 15) begin bad++; $display("FAIL stall_done_cycle got=%0d want=15", done_at); end
        total++; if (rd_cnt - rd0 != 4) begin bad++; $display("FAIL stall_rd_count got=%0d want=4", rd_cnt - rd0); end
        total++; if (empty_viol != ev0) begin bad++; $display("FAIL stall_rd_empty got=%0d want=0", empty_viol - ev0); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL stall_word got=none want=%0d", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL stall_word got=%0d want=%0d", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL stall_extra got=%0d want=0", obs_q.size() - obs_rd); end
        next_cycle();
    endtask

    task automatic test_len_zero();
        word_q_t words;
        int rd0, bz0;
        logic d1, d2;
        words = '{8'h55};
        fifo_load(words);
        rd0 = rd_cnt; bz0 = busy_cnt;
        start = 1'b1; len = 8'd0; d1 = 1'b0; d2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) d1 = done;
            if (c == 2) d2 = done;
            next_cycle(); start = 1'b0;
        end
        total++; if (d1 !== 1'b1) begin bad++; $display("FAIL len0_done got=%b want=1", d1); end
        total++; if (d2 !== 1'b0) begin bad++; $display("FAIL len0_done_once got=%b want=0", d2); end
        total++; if (busy_cnt != bz0) begin bad++; $display("FAIL len0_busy got=%0d want=0 cycles", busy_cnt - bz0); end
        total++; if (rd_cnt != rd0) begin bad++; $display("FAIL len0_rd_en got=%0d want=0", rd_cnt - rd0); end
        fifo_clear();
    endtask

    task automatic test_start_ignored();
        word_q_t words;
        logic [DATA_W-1:0] e;
        int cyc, done_at, rd0, dn0;
        words = '{8'd30, 8'd31, 8'd32, 8'd33, 8'd34};
        fifo_load(words);
        exp_q.push_back(8'd30); exp_q.push_back(8'd31); exp_q.push_back(8'd32);
        obs_rd = obs_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        m_ready = 1'b1; start = 1'b1; len = 8'd3;
        done_at = -1; cyc = 0;
        while (cyc < 40 && done_at < 0) begin
            @(negedge clk);
            if (done) done_at = cyc;
            next_cycle(); cyc++;
            start = (cyc == 2 || cyc == 4);
            len = 8'd5;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (done_at != 6) begin bad++; $display("FAIL ign_done_cycle got=%0d want=6", done_at); end
        total++; if (rd_cnt - rd0 != 3) begin bad++; $display("FAIL ign_rd_count got=%0d want=3", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_cnt - dn0); end
        total++; if (fifo_cnt != 2) begin bad++; $display("FAIL ign_fifo_left got=%0d want=2", fifo_cnt); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL ign_word got=none want=%0d", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL ign_word got=%0d want=%0d", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL ign_extra got=%0d want=0", obs_q.size() - obs_rd); end
        fifo_clear();
    endtask

    task automatic test_reset_mid_burst();
        word_q_t words;
        logic [DATA_W-1:0] e;
        int cyc, done_at, rd0, dn0;
        words = '{8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55};
        fifo_load(words);
        m_ready = 1'b0; start = 1'b1; len = 8'd6;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                total++; if (m_valid !== 1'b1 || m_data !== 8'd50) begin bad++; $display("FAIL rstmid_pre got=%b/%0d want=1/50", m_valid, m_data); end
            end
            next_cycle(); start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en got=%b want=0", rd_en); end
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
        next_cycle();
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done_late got=%b want=0", done); end
        next_cycle();
        m_ready = 1'b1;
        fifo_clear();
        exp_q.delete();
        words = '{8'd60, 8'd61};
        fifo_load(words);
        foreach (words[i]) exp_q.push_back(words[i]);
        obs_rd = obs_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        start = 1'b1; len = 8'd2;
        done_at = -1; cyc = 0;
        while (cyc < 40 && done_at < 0) begin
            @(negedge clk);
            if (done) done_at = cyc;
            next_cycle(); start = 1'b0; cyc++;
        end
        repeat (2) @(negedge clk);
        total++; if (done_at != 5) begin bad++; $display("FAIL rstmid_new_done got=%0d want=5", done_at); end
        total++; if (rd_cnt - rd0 != 2) begin bad++; $display("FAIL rstmid_new_rd got=%0d want=2", rd_cnt - rd0); end
        total++; if (done_cnt - dn0 != 1) begin bad++; $display("FAIL rstmid_new_done_count got=%0d want=1", done_cnt - dn0); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL rstmid_word got=none want=%0d", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL rstmid_word got=%0d want=%0d", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_q.size() != obs_rd) begin bad++; $display("FAIL rstmid_extra got=%0d want=0", obs_q.size() - obs_rd); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
